// File: rtl/accel_fifo_port.sv
// Accelerator-side responder for the router data bus: a to-accelerator queue filled by router puts
// and a from-accelerator queue drained by router gets, with registered empty/full flags and sticky errors.
module accel_fifo_port #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              put_req,
  input  logic [DATA_W-1:0] router_wdata,
  input  logic              get_req,
  output logic [DATA_W-1:0] router_rdata,
  output logic              get_ack,
  output logic              to_empty,
  output logic              to_full,
  output logic              from_empty,
  output logic              from_full,
  output logic [DATA_W-1:0] acc_rdata,
  input  logic              acc_pop,
  input  logic [DATA_W-1:0] acc_wdata,
  input  logic              acc_push,
  output logic [ADDR_W:0]   to_count,
  output logic [ADDR_W:0]   from_count,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_PTR = ADDR_W'(1);

  logic [DATA_W-1:0] r_toMem   [DEPTH];
  logic [DATA_W-1:0] r_fromMem [DEPTH];

  logic [ADDR_W-1:0] r_toWr, r_toRd, r_fromWr, r_fromRd;
  logic [ADDR_W:0]   r_toCount, r_fromCount;
  logic              r_toEmpty, r_toFull, r_fromEmpty, r_fromFull;
  logic [DATA_W-1:0] r_routerRdata;
  logic              r_getAck;
  logic              r_overflow, r_underflow;

  logic              w_toWrite, w_toRead, w_fromWrite, w_fromRead;
  logic              w_ovfEvent, w_unfEvent;
  logic [ADDR_W:0]   w_toCountNext, w_fromCountNext;

  // Acceptance uses the registered (pre-edge) flags, so a full queue rejects a write even if it is read this cycle.
  assign w_toWrite   = put_req  & ~r_toFull;
  assign w_toRead    = acc_pop  & ~r_toEmpty;
  assign w_fromWrite = acc_push & ~r_fromFull;
  assign w_fromRead  = get_req  & ~r_fromEmpty;

  assign w_ovfEvent = (put_req & r_toFull)  | (acc_push & r_fromFull);
  assign w_unfEvent = (acc_pop & r_toEmpty) | (get_req  & r_fromEmpty);

  always_comb begin
    w_toCountNext = r_toCount;
    if (w_toWrite && !w_toRead) begin
      w_toCountNext = r_toCount + ONE_CNT;
    end else if (!w_toWrite && w_toRead) begin
      w_toCountNext = r_toCount - ONE_CNT;
    end
  end

  always_comb begin
    w_fromCountNext = r_fromCount;
    if (w_fromWrite && !w_fromRead) begin
      w_fromCountNext = r_fromCount + ONE_CNT;
    end else if (!w_fromWrite && w_fromRead) begin
      w_fromCountNext = r_fromCount - ONE_CNT;
    end
  end

  // Storage is never reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (!reset && w_toWrite) begin
      r_toMem[r_toWr] <= router_wdata;
    end
    if (!reset && w_fromWrite) begin
      r_fromMem[r_fromWr] <= acc_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_toWr      <= '0;
      r_toRd      <= '0;
      r_toCount   <= '0;
      r_toEmpty   <= 1'b1;
      r_toFull    <= 1'b0;
    end else begin
      if (w_toWrite) begin
        r_toWr <= r_toWr + ONE_PTR;
      end
      if (w_toRead) begin
        r_toRd <= r_toRd + ONE_PTR;
      end
      r_toCount <= w_toCountNext;
      r_toEmpty <= (w_toCountNext == '0);
      r_toFull  <= (w_toCountNext == FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fromWr      <= '0;
      r_fromRd      <= '0;
      r_fromCount   <= '0;
      r_fromEmpty   <= 1'b1;
      r_fromFull    <= 1'b0;
      r_routerRdata <= '0;
      r_getAck      <= 1'b0;
    end else begin
      if (w_fromWrite) begin
        r_fromWr <= r_fromWr + ONE_PTR;
      end
      if (w_fromRead) begin
        r_fromRd      <= r_fromRd + ONE_PTR;
        r_routerRdata <= r_fromMem[r_fromRd];
      end
      r_getAck    <= w_fromRead;
      r_fromCount <= w_fromCountNext;
      r_fromEmpty <= (w_fromCountNext == '0);
      r_fromFull  <= (w_fromCountNext == FULL_CNT);
    end
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovfEvent) begin
        r_overflow <= 1'b1;
      end else if (err_clr) begin
        r_overflow <= 1'b0;
      end
      if (w_unfEvent) begin
        r_underflow <= 1'b1;
      end else if (err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign acc_rdata    = r_toMem[r_toRd];
  assign router_rdata = r_routerRdata;
  assign get_ack      = r_getAck;
  assign to_empty     = r_toEmpty;
  assign to_full      = r_toFull;
  assign from_empty   = r_fromEmpty;
  assign from_full    = r_fromFull;
  assign to_count     = r_toCount;
  assign from_count   = r_fromCount;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_accel_fifo_port.sv
// Bench for accel_fifo_port: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of the two FIFOs.
module tb_accel_fifo_port;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              put_req = 1'b0;
  logic [DATA_W-1:0] router_wdata = '0;
  logic              get_req = 1'b0;
  logic [DATA_W-1:0] router_rdata;
  logic              get_ack;
  logic              to_empty, to_full, from_empty, from_full;
  logic [DATA_W-1:0] acc_rdata;
  logic              acc_pop = 1'b0;
  logic [DATA_W-1:0] acc_wdata = '0;
  logic              acc_push = 1'b0;
  logic [ADDR_W:0]   to_count, from_count;
  logic              overflow, underflow;
  logic              err_clr = 1'b0;

  int checkCount = 0;
  int errorCount = 0;

  logic [31:0] toQ[$];
  logic [31:0] fromQ[$];
  logic [31:0] expRdata;
  logic        expAck, expOvf, expUnf;

  accel_fifo_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .put_req(put_req), .router_wdata(router_wdata),
    .get_req(get_req), .router_rdata(router_rdata), .get_ack(get_ack),
    .to_empty(to_empty), .to_full(to_full), .from_empty(from_empty), .from_full(from_full),
    .acc_rdata(acc_rdata), .acc_pop(acc_pop), .acc_wdata(acc_wdata), .acc_push(acc_push),
    .to_count(to_count), .from_count(from_count),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkState();
    checkOutput("to_count",     32'(to_count),     32'(toQ.size()));
    checkOutput("from_count",   32'(from_count),   32'(fromQ.size()));
    checkOutput("to_empty",     32'(to_empty),     32'(toQ.size() == 0));
    checkOutput("to_full",      32'(to_full),      32'(toQ.size() == DEPTH));
    checkOutput("from_empty",   32'(from_empty),   32'(fromQ.size() == 0));
    checkOutput("from_full",    32'(from_full),    32'(fromQ.size() == DEPTH));
    checkOutput("overflow",     32'(overflow),     32'(expOvf));
    checkOutput("underflow",    32'(underflow),    32'(expUnf));
    checkOutput("get_ack",      32'(get_ack),      32'(expAck));
    checkOutput("router_rdata", router_rdata,      expRdata);
    if (toQ.size() != 0) begin
      checkOutput("acc_rdata", acc_rdata, toQ[0]);
    end
  endtask

  // Drive one cycle of inputs, advance the model by the queue rules, then compare after the edge.
  task automatic applyStimulus(input logic put, input logic [31:0] wd, input logic get,
                               input logic pop, input logic push, input logic [31:0] awd,
                               input logic clr, input logic rst);
    logic toFull, toEmpty, fromFull, fromEmpty, ovfEv, unfEv;
    put_req = put; router_wdata = wd; get_req = get; acc_pop = pop;
    acc_push = push; acc_wdata = awd; err_clr = clr; reset = rst;
    if (rst) begin
      toQ.delete(); fromQ.delete();
      expRdata = '0; expAck = 1'b0; expOvf = 1'b0; expUnf = 1'b0;
    end else begin
      toFull    = (toQ.size() == DEPTH);
      toEmpty   = (toQ.size() == 0);
      fromFull  = (fromQ.size() == DEPTH);
      fromEmpty = (fromQ.size() == 0);
      ovfEv = (put && toFull) || (push && fromFull);
      unfEv = (pop && toEmpty) || (get && fromEmpty);
      if (pop && !toEmpty) void'(toQ.pop_front());
      if (put && !toFull) toQ.push_back(wd);
      expAck = 1'b0;
      if (get && !fromEmpty) begin
        expRdata = fromQ.pop_front();
        expAck = 1'b1;
      end
      if (push && !fromFull) fromQ.push_back(awd);
      if (ovfEv) expOvf = 1'b1; else if (clr) expOvf = 1'b0;
      if (unfEv) expUnf = 1'b1; else if (clr) expUnf = 1'b0;
    end
    @(posedge clk);
    #1;
    checkState();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    idle();

    for (int i = 0; i < 16; i++) applyStimulus(1, 32'h100 + i, 0, 0, 0, 0, 0, 0);
    checkOutput("fill_to_full", 32'(to_full), 32'd1);
    checkOutput("fill_to_count", 32'(to_count), 32'd16);
    checkOutput("fill_head", acc_rdata, 32'h100);

    applyStimulus(1, 32'hDEAD, 0, 0, 0, 0, 0, 0);
    checkOutput("put_full_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      checkOutput("drain_order", acc_rdata, 32'h100 + i);
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
    end
    checkOutput("drain_empty", 32'(to_empty), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);

    applyStimulus(0, 0, 0, 0, 1, 32'hA5A5_0001, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("get_data", router_rdata, 32'hA5A5_0001);
    checkOutput("get_ack_pulse", 32'(get_ack), 32'd1);
    idle();
    checkOutput("get_ack_drop", 32'(get_ack), 32'd0);

    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("empty_get_hold", router_rdata, 32'hA5A5_0001);
    checkOutput("empty_get_unf", 32'(underflow), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("err_clr_unf", 32'(underflow), 32'd0);

    // Error in the same cycle as err_clr must win.
    applyStimulus(0, 0, 1, 0, 0, 0, 1, 0);
    checkOutput("err_beats_clr", 32'(underflow), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 0, 1, 32'h200 + i, 0, 0);
    applyStimulus(0, 0, 1, 0, 1, 32'hBAD, 0, 0);
    checkOutput("full_pushget_data", router_rdata, 32'h200);
    checkOutput("full_pushget_ovf", 32'(overflow), 32'd1);
    checkOutput("full_pushget_cnt", 32'(from_count), 32'd15);

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 32'h300, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) applyStimulus(1, 32'h301 + i, 0, 1, 1, 32'h400 + i, 0, 0);
    checkOutput("wrap_head", acc_rdata, 32'h328);
    applyStimulus(1, 32'h999, 1, 1, 1, 32'h999, 0, 1);
    checkOutput("midreset_to_empty", 32'(to_empty), 32'd1);
    checkOutput("midreset_from_empty", 32'(from_empty), 32'd1);
    checkOutput("midreset_rdata", router_rdata, 32'd0);

    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom_range(99) < 55), $urandom(), ($urandom_range(99) < 45),
                    ($urandom_range(99) < 45), ($urandom_range(99) < 55), $urandom(),
                    ($urandom_range(99) < 8), ($urandom_range(999) < 5));
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
